// File: rtl/integral_image_gen.sv
`default_nettype none
// ============================================================================
// Module      : integral_image_gen
// Description : Streaming integral-image generator. Consumes raster-order
//               grayscale pixels and writes ii(x,y) = row_sum(x,y) + ii(x,y-1)
//               to an external buffer through a fixed 2-stage pipeline.
//               One IMG_WIDTH-entry line buffer holds the previous row.
// Option      : define II_FRAME_CHECK_EN to enable the sticky frame_err
//               flag (set when sof aborts a frame in progress).
// Revision    : 1.0 - initial release
// ============================================================================
module integral_image_gen #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int PIX_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sof,
    input  logic                 pix_valid,
    input  logic [PIX_WIDTH-1:0] pix_data,
    output logic                 wr_en,
    output logic [14:0]          wr_addr,
    output logic signed [20:0]   wr_data,
    output logic                 frame_done,
    output logic                 frame_err
);

    localparam int c_DATA_W = 21;
    localparam int c_ADDR_W = 15;
    localparam int c_XW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_YW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [c_XW-1:0]     c_X_LAST = c_XW'(IMG_WIDTH - 1);
    localparam logic [c_YW-1:0]     c_Y_LAST = c_YW'(IMG_HEIGHT - 1);
    localparam logic [c_XW-1:0]     c_X_ONE  = 1;
    localparam logic [c_YW-1:0]     c_Y_ONE  = 1;
    localparam logic [c_ADDR_W-1:0] c_A_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Raster position of the next pixel and the running row sum
    logic [c_XW-1:0]     r_x;
    logic [c_YW-1:0]     r_y;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_DATA_W-1:0] r_acc;

    // Position of the pixel being consumed this cycle (sof forces origin)
    logic                w_accept;
    logic                w_last;
    logic [c_XW-1:0]     w_px;
    logic [c_YW-1:0]     w_py;
    logic [c_ADDR_W-1:0] w_pa;
    logic [c_DATA_W-1:0] w_row_sum;

    // Stage 1: row sum, position and the upper term read from the line buffer
    logic                r_s1_valid;
    logic                r_s1_last;
    logic                r_s1_row0;
    logic [c_XW-1:0]     r_s1_x;
    logic [c_ADDR_W-1:0] r_s1_addr;
    logic [c_DATA_W-1:0] r_s1_rowsum;
    logic [c_DATA_W-1:0] r_s1_up;

    // Stage 2 result
    logic [c_DATA_W-1:0] w_ii;

    // Previous-row integral values, overwritten in place as each row is produced
    logic [c_DATA_W-1:0] r_line [IMG_WIDTH];

    // Next-state, pixel acceptance and row-sum datapath
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = pix_valid && (sof || (r_state == S_ACCUM));
        w_px        = sof ? '0 : r_x;
        w_py        = sof ? '0 : r_y;
        w_pa        = sof ? '0 : r_addr;
        w_last      = w_accept && (w_px == c_X_LAST) && (w_py == c_Y_LAST);
        w_row_sum   = ((w_px == '0) ? '0 : r_acc)
                    + {{(c_DATA_W-PIX_WIDTH){1'b0}}, pix_data};

        if (w_accept) begin
            w_state_nxt = w_last ? S_DONE : S_ACCUM;
        end else begin
            case (r_state)
                S_ACCUM: w_state_nxt = S_ACCUM;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Raster counters and row accumulator; gaps leave them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_acc <= w_row_sum;
            if (w_last) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= '0;
            end else begin
                r_addr <= w_pa + c_A_ONE;
                if (w_px == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= w_py + c_Y_ONE;
                end else begin
                    r_x <= w_px + c_X_ONE;
                    r_y <= w_py;
                end
            end
        end
    end

    // Pipeline stage 1 control and row sum capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_row0   <= 1'b0;
            r_s1_x      <= '0;
            r_s1_addr   <= '0;
            r_s1_rowsum <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last   <= w_last;
                r_s1_row0   <= (w_py == '0);
                r_s1_x      <= w_px;
                r_s1_addr   <= w_pa;
                r_s1_rowsum <= w_row_sum;
            end
        end
    end

    // Row 0 ignores the buffer so stale or uninitialised contents never leak in
    assign w_ii = r_s1_rowsum + (r_s1_row0 ? '0 : r_s1_up);

    // Line buffer write-back and registered read of the upper term; the bypass
    // covers a same-column write in flight (only possible for 1-wide images)
    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_line[r_s1_x] <= w_ii;
        end
        if (w_accept) begin
            r_s1_up <= (r_s1_valid && (r_s1_x == w_px)) ? w_ii : r_line[w_px];
        end
    end

    // Pipeline stage 2: buffer write port and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= r_s1_valid;
            frame_done <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                wr_addr <= r_s1_addr;
                wr_data <= w_ii;
            end
        end
    end

`ifdef II_FRAME_CHECK_EN
    logic w_abort;
    assign w_abort = pix_valid && sof && (r_state == S_ACCUM);

    // Sticky short-frame flag; a new abort wins over a completing frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (w_abort) begin
            frame_err <= 1'b1;
        end else if (r_s1_valid && r_s1_last) begin
            frame_err <= 1'b0;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_integral_image_gen.sv
`timescale 1ns/1ps
module tb_integral_image_gen;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;
`ifdef II_FRAME_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                sof       = 1'b0;
    logic                pix_valid = 1'b0;
    logic [3:0]          pix_data  = 4'd0;
    logic                wr_en;
    logic [14:0]         wr_addr;
    logic signed [20:0]  wr_data;
    logic                frame_done;
    logic                frame_err;

    integral_image_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIX_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int due;
        int addr;
        int data;
        bit last;
    } exp_t;

    exp_t q[$];
    int   mii [N];
    int   dut_mem [N];
    int   cyc        = 0;
    bit   m_in_frame = 1'b0;
    int   m_pos      = 0;
    bit   m_err      = 1'b0;
    int   last_addr  = 0;
    int   last_data  = 0;
    int   n_writes   = 0;
    int   n_done     = 0;

    always @(negedge rst_n) begin
        q.delete();
        m_in_frame = 1'b0;
        m_pos      = 0;
        m_err      = 1'b0;
        last_addr  = 0;
        last_data  = 0;
    end

    // Accepted pixel -> expected write one edge later (2-stage pipeline)
    always @(posedge clk) begin
        int x, y, v;
        cyc++;
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc && q[0].last) m_err = 1'b0;
            if (pix_valid && (sof || m_in_frame)) begin
                if (sof) begin
                    if (m_in_frame) m_err = ERR_EN;
                    m_pos = 0;
                end
                x = m_pos % W;
                y = m_pos / W;
                v = int'(pix_data);
                if (x > 0)          v += mii[m_pos-1];
                if (y > 0)          v += mii[m_pos-W];
                if (x > 0 && y > 0) v -= mii[m_pos-W-1];
                mii[m_pos] = v;
                q.push_back('{cyc + 1, m_pos, v, (m_pos == N-1)});
                if (m_pos == N-1) begin
                    m_in_frame = 1'b0;
                    m_pos      = 0;
                end else begin
                    m_in_frame = 1'b1;
                    m_pos++;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_wr_en",      wr_en,      0);
            chk("rst_wr_addr",    wr_addr,    0);
            chk("rst_wr_data",    wr_data,    0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_frame_err",  frame_err,  0);
        end else begin
            if (wr_en) begin
                n_writes++;
                if (wr_addr < N) dut_mem[wr_addr] = int'(wr_data);
            end
            if (frame_done) n_done++;
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("wr_en",      wr_en,      1);
                chk("wr_addr",    wr_addr,    q[0].addr);
                chk("wr_data",    wr_data,    q[0].data);
                chk("frame_done", frame_done, q[0].last);
                last_addr = q[0].addr;
                last_data = q[0].data;
                void'(q.pop_front());
            end else begin
                chk("idle_wr_en",      wr_en,      0);
                chk("idle_frame_done", frame_done, 0);
                chk("hold_wr_addr",    wr_addr,    last_addr);
                chk("hold_wr_data",    wr_data,    last_data);
            end
            chk("frame_err", frame_err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit s, input logic [3:0] d);
        @(posedge clk);
        #1;
        pix_valid = v;
        sof       = s;
        pix_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    // mode: 0 all ones, 1 all 15, 2 x mod 16, 3 random
    task automatic send_pixels(input int mode, input bit gaps, input int start,
                               input int count, input bit sof_first);
        logic [3:0] d;
        for (int i = start; i < start + count; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 7) == 0) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
            end
            case (mode)
                0:       d = 4'd1;
                1:       d = 4'd15;
                2:       d = 4'(i % W);
                default: d = 4'($urandom_range(0, 15));
            endcase
            drive(1'b1, sof_first && (i == start), d);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_wr_en",   wr_en,   0);
        chk("reset_wr_data", wr_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // pix_valid without sof while idle must be ignored
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 4'($urandom_range(0, 15)));
            drive(1'b0, 1'b0, 4'd0);
        end
        idle(4);
        chk("idle_pulses_writes", n_writes, 0);

        // All-15 frame, continuous valid
        n_writes = 0; n_done = 0;
        send_pixels(1, 1'b0, 0, N, 1'b1);
        idle(6);
        chk("f15_writes",     n_writes, N);
        chk("f15_done",       n_done, 1);
        chk("f15_last",       dut_mem[N-1], 288000);
        chk("f15_sign",       dut_mem[N-1] < 0, 0);
        chk("f15_model_last", mii[N-1], 288000);
        chk("f15_x3_y2",      dut_mem[2*W+3], 180);

        // 500 pixels, then sof aborts and a full ones frame follows
        n_writes = 0; n_done = 0;
        send_pixels(3, 1'b0, 0, 500, 1'b1);
        send_pixels(0, 1'b0, 0, 50, 1'b1);
        chk("abort_err",  frame_err, ERR_EN);
        chk("abort_done", n_done, 0);
        send_pixels(0, 1'b0, 50, N - 50, 1'b0);
        idle(6);
        chk("ones_a0",     dut_mem[0], 1);
        chk("ones_a159",   dut_mem[159], 160);
        chk("ones_x5_y1",  dut_mem[W+5], 12);
        chk("ones_a19199", dut_mem[N-1], 19200);
        chk("ones_writes", n_writes, N + 500);
        chk("ones_done",   n_done, 1);
        chk("ones_err",    frame_err, 0);

        // Reset at pixel 1000, stray pixels, then a gapped x mod 16 frame
        send_pixels(3, 1'b1, 0, 1000, 1'b1);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        #1;
        chk("midrst_wr_en",   wr_en,   0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_writes = 0; n_done = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'd7);
        idle(4);
        chk("post_rst_writes", n_writes, 0);
        send_pixels(2, 1'b1, 0, N, 1'b1);
        idle(6);
        chk("mod_writes", n_writes, N);
        chk("mod_done",   n_done, 1);
        chk("mod_a15",    dut_mem[15], 120);
        chk("mod_x15_y1", dut_mem[W+15], 240);
        chk("mod_last",   dut_mem[N-1], 144000);
        chk("mod_queue",  q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/integral_image_gen.md
INTEGRAL_IMAGE_GEN -- requirements
Module: integral_image_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 160, image columns.
REQ-002 SHALL have parameter IMG_HEIGHT, default 120, image rows.
REQ-003 SHALL have parameter PIX_WIDTH, default 4, unsigned grayscale pixel width.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: sof  input  1  start-of-frame; qualifies the pixel presented in the same cycle as pixel (0,0).
REQ-007 Port: pix_valid  input  1  pix_data valid this cycle; no backpressure.
REQ-008 Port: pix_data  input  PIX_WIDTH  grayscale pixel, raster order, left to right, top to bottom.
REQ-009 Port: wr_en  output  1  buffer write strobe.
REQ-010 Port: wr_addr  output  15  buffer address = y*IMG_WIDTH + x.
REQ-011 Port: wr_data  output  21  signed integral value; always non-negative.
REQ-012 Port: frame_done  output  1  one-cycle pulse once the last integral value has been written; starts detection.
REQ-013 Port: frame_err  output  1  sticky malformed-frame flag (see Configuration).

Function
REQ-014 SHALL compute ii(x,y) = sum of pix over all (i<=x, j<=y) as row_sum(x,y) + ii(x,y-1); ii(x,-1) = 0.
REQ-015 SHALL hold ii(*,y-1) in an internal IMG_WIDTH x 21-bit line buffer, overwritten in place as row y is produced.
REQ-016 SHALL use a 21-bit row accumulator, cleared at x=0; max value 160*120*15 = 288000 fits with no overflow at defaults.
REQ-017 States: IDLE (wait for sof), ACCUM (accepting pixels), DONE (one cycle, emits frame_done) -> IDLE.
REQ-018 IDLE -> ACCUM on pix_valid && sof; that pixel is consumed as (0,0). pix_valid without sof in IDLE is ignored.
REQ-019 In ACCUM, each pix_valid cycle consumes one pixel and advances x; x wraps to 0 and y increments at x = IMG_WIDTH-1.
REQ-020 Gaps (pix_valid=0) SHALL stall the pipeline state with no write produced.
REQ-021 Latency: pixel accepted at edge N SHALL yield wr_en=1 with its wr_addr/wr_data during cycle N+2 (fixed 2-stage pipeline).
REQ-022 After the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted, SHALL enter DONE; frame_done SHALL pulse in the same cycle as the final write (address 19199).
REQ-023 Pixels arriving in DONE or IDLE without sof SHALL be dropped.
REQ-024 sof during ACCUM SHALL abort the current frame: counters and accumulator restart, and the sof pixel becomes (0,0) of the new frame; in-flight writes still complete; no frame_done for the aborted frame.
REQ-025 wr_en SHALL be 0 whenever no valid result exits the pipeline; wr_addr/wr_data hold their last values.

Reset
REQ-026 On rst_n=0 asynchronously: state=IDLE, x=y=0, accumulator=0, pipeline valids=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0.
REQ-027 Line buffer contents SHALL need no reset; row 0 SHALL use zero as the upper term regardless of buffer contents.
REQ-028 Reset mid-frame SHALL discard the frame; no write or frame_done after rst_n deassertion until a new sof.

Configuration
REQ-029 Macro II_FRAME_CHECK_EN defined: frame_err SHALL set when sof arrives in ACCUM (short frame), and clear on the next frame_done or on reset.
REQ-030 Macro II_FRAME_CHECK_EN undefined: frame_err SHALL be tied to 0 and no check logic synthesized; all other behaviour is identical.

Verification
REQ-031 All-ones frame, continuous valid -> wr_data at (x,y) = (x+1)(y+1); addr 159 = 160, addr 19199 = 19200; one frame_done.
REQ-032 All-15 frame -> addr 19199 wr_data = 288000, no sign bit set; frame_done coincident with the final write.
REQ-033 Pixel = x mod 16 with random pix_valid gaps -> every write matches the reference model, exactly 19200 writes, each 2 accepted-cycles late.
REQ-034 sof after 500 pixels, then full ones frame -> new frame addr 0 = 1; with II_FRAME_CHECK_EN frame_err=1 until that frame_done; without it frame_err stays 0.
REQ-035 rst_n low for 1 cycle at pixel 1000 -> outputs zero immediately; no writes until sof; next full frame correct.
REQ-036 pix_valid pulses without sof in IDLE -> no wr_en, state remains IDLE.
